// File: rtl/max1820_sync_seq.sv
// MAX1820 sync sequencer: picks N in 2..8 so dspclk/N lands in 15..21 MHz (or USB), then disable/hold-off/apply/settle.
// Apply edge is 2+S+HOLDOFF edges after the strobe. `define MAX1820_SYNC_USB_FALLBACK_EN makes no-fit run on USB instead of faulting.
module max1820_sync_seq #(
    parameter int HOLDOFF = 64,
    parameter int SETTLE  = 256
) (
    input  logic       dspclk,
    input  logic       rst,
    input  logic [7:0] cfg_freq,
    input  logic       force_usb,
    input  logic       cfg_strobe,
    input  logic       cfg_enable,
    output logic       sync_enable,
    output logic [2:0] div_ctl,
    output logic       mux_ctl,
    output logic       busy,
    output logic       no_fit
);
    typedef enum logic [2:0] {
        S_IDLE, S_DISABLE, S_SEARCH, S_HOLDOFF, S_APPLY, S_SETTLE, S_RUN, S_FAULT
    } state_t;

    localparam logic [15:0] HOLDOFF_LAST = 16'(HOLDOFF - 1);
    localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE - 1);

    state_t      r_state;
    logic [7:0]  r_freq;
    logic        r_usb;
    logic [3:0]  r_n;
    logic [7:0]  r_lo;
    logic [7:0]  r_hi;
    logic        r_fit;
    logic [15:0] r_cnt;

    logic w_in_range;
    logic w_to_fault;

    assign w_in_range = (r_freq >= r_lo) && (r_freq <= r_hi);
`ifdef MAX1820_SYNC_USB_FALLBACK_EN
    assign w_to_fault = 1'b0;
`else
    assign w_to_fault = no_fit;
`endif

    always_ff @(posedge dspclk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_freq      <= 8'd0;
            r_usb       <= 1'b0;
            r_n         <= 4'd0;
            r_lo        <= 8'd0;
            r_hi        <= 8'd0;
            r_fit       <= 1'b0;
            r_cnt       <= 16'd0;
            sync_enable <= 1'b0;
            div_ctl     <= 3'd0;
            mux_ctl     <= 1'b0;
            busy        <= 1'b0;
            no_fit      <= 1'b0;
        end else if (cfg_strobe) begin
            // A strobe aborts whatever is in flight, including a SETTLE terminal count.
            r_freq      <= cfg_freq;
            r_usb       <= force_usb;
            r_cnt       <= 16'd0;
            sync_enable <= 1'b0;
            busy        <= 1'b1;
            r_state     <= S_DISABLE;
        end else begin
            case (r_state)
                S_DISABLE: begin
                    r_n     <= 4'd2;
                    r_lo    <= 8'd30;
                    r_hi    <= 8'd42;
                    r_state <= S_SEARCH;
                end
                S_SEARCH: begin
                    if (r_usb) begin
                        r_fit   <= 1'b0;
                        no_fit  <= 1'b0;
                        r_cnt   <= 16'd0;
                        r_state <= S_HOLDOFF;
                    end else if (w_in_range) begin
                        r_fit   <= 1'b1;
                        no_fit  <= 1'b0;
                        r_cnt   <= 16'd0;
                        r_state <= S_HOLDOFF;
                    end else if (r_n == 4'd8) begin
                        r_fit   <= 1'b0;
                        no_fit  <= 1'b1;
                        r_cnt   <= 16'd0;
                        r_state <= S_HOLDOFF;
                    end else begin
                        // Running sums replace 15*N and 21*N.
                        r_n  <= r_n + 4'd1;
                        r_lo <= r_lo + 8'd15;
                        r_hi <= r_hi + 8'd21;
                    end
                end
                S_HOLDOFF: begin
                    if (r_cnt == HOLDOFF_LAST) begin
                        r_cnt   <= 16'd0;
                        r_state <= S_APPLY;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_APPLY: begin
                    if (r_fit) begin
                        div_ctl <= 3'(r_n - 4'd1);
                        mux_ctl <= 1'b1;
                    end else begin
                        mux_ctl <= 1'b0;
                    end
                    r_cnt   <= 16'd0;
                    r_state <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (r_cnt == SETTLE_LAST) begin
                        r_cnt   <= 16'd0;
                        busy    <= 1'b0;
                        r_state <= w_to_fault ? S_FAULT : S_RUN;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_RUN:   sync_enable <= cfg_enable;
                S_FAULT: sync_enable <= 1'b0;
                S_IDLE:  sync_enable <= 1'b0;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_max1820_sync_seq.sv
`timescale 1ns/1ps
module tb_max1820_sync_seq;
    localparam int HOLD = 4;
    localparam int SETL = 8;

    logic       dspclk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] cfg_freq = 8'd0;
    logic       force_usb = 1'b0;
    logic       cfg_strobe = 1'b0;
    logic       cfg_enable = 1'b1;
    logic       sync_enable;
    logic [2:0] div_ctl;
    logic       mux_ctl;
    logic       busy;
    logic       no_fit;

    int n_chk  = 0;
    int n_pass = 0;
    int exp_div = 0;
    int exp_mux = 0;
    int exp_nf  = 0;

    always #5 dspclk = ~dspclk;

    max1820_sync_seq #(.HOLDOFF(HOLD), .SETTLE(SETL)) dut (
        .dspclk(dspclk), .rst(rst), .cfg_freq(cfg_freq), .force_usb(force_usb),
        .cfg_strobe(cfg_strobe), .cfg_enable(cfg_enable), .sync_enable(sync_enable),
        .div_ctl(div_ctl), .mux_ctl(mux_ctl), .busy(busy), .no_fit(no_fit)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    // Lowest N with 15*N <= f <= 21*N, or 0 when nothing fits.
    function automatic int pick_n(input int f);
        for (int n = 2; n <= 8; n++)
            if (15 * n <= f && f <= 21 * n) return n;
        return 0;
    endfunction

    // Strobes one configuration and checks every edge against the timeline.
    // mode 0: run to RUN/FAULT + tail; 1: abort mid-SETTLE; 2: abort on SETTLE terminal
    // count; 3: stop mid-HOLDOFF; 4: abort at a random edge. Call just after a negedge.
    task automatic run_seq(input int f, input bit fu, input int mode, input int tail, input bit rand_en);
        int n, s, a, r, last_k, nd, nm;
        bit fit, nf, to_run, en_at_edge;
        n   = pick_n(f);
        fit = !fu && (n != 0);
        nf  = !fu && (n == 0);
        s   = fu ? 1 : (fit ? n - 1 : 7);
        a   = 2 + s + HOLD;
        r   = a + SETL;
`ifdef MAX1820_SYNC_USB_FALLBACK_EN
        to_run = 1'b1;
`else
        to_run = !nf;
`endif
        nd = fit ? n - 1 : exp_div;
        nm = fit ? 1 : 0;
        case (mode)
            1:       last_k = a + 3;
            2:       last_k = r - 1;
            3:       last_k = 1 + s + 2;
            4:       last_k = $urandom_range(0, r);
            default: last_k = r + tail;
        endcase
        en_at_edge = cfg_enable;
        cfg_freq   = 8'(f);
        force_usb  = fu;
        cfg_strobe = 1'b1;
        for (int k = 0; k <= last_k; k++) begin
            @(negedge dspclk);
            cfg_strobe = 1'b0;
            if (k >= 1) check("busy", busy, (k < r) ? 1 : 0);
            check("div_ctl", div_ctl, (k >= a) ? nd : exp_div);
            check("mux_ctl", mux_ctl, (k >= a) ? nm : exp_mux);
            if (k >= a) check("no_fit", no_fit, nf);
            check("sync_enable", sync_enable, (k > r && to_run) ? en_at_edge : 0);
            if (rand_en && k >= r) cfg_enable = ($urandom_range(0, 3) != 0);
            en_at_edge = cfg_enable;
        end
        if (last_k >= a) begin
            exp_div = nd;
            exp_mux = nm;
        end
        if (last_k >= 1 + s) exp_nf = nf;
    endtask

    initial begin
        int f, md;
        bit fu;
        int bnd_f[8] = '{30, 42, 45, 168, 29, 43, 44, 169};

        repeat (2) @(negedge dspclk);
        check("rst_sync", sync_enable, 0);
        check("rst_div", div_ctl, 0);
        check("rst_mux", mux_ctl, 0);
        check("rst_busy", busy, 0);
        check("rst_nofit", no_fit, 0);
        rst = 1'b0;
        repeat (5) begin
            @(negedge dspclk);
            check("idle_sync", sync_enable, 0);
            check("idle_busy", busy, 0);
        end

        run_seq(100, 1'b0, 0, 4, 1'b0);
        foreach (bnd_f[i]) run_seq(bnd_f[i], 1'b0, 0, 3, 1'b0);
        run_seq(43, 1'b0, 0, 100, 1'b0);
        run_seq(80, 1'b1, 0, 3, 1'b0);
        run_seq(60, 1'b0, 0, 5, 1'b0);
        run_seq(150, 1'b0, 0, 5, 1'b0);
        run_seq(60, 1'b0, 1, 0, 1'b0);
        run_seq(150, 1'b0, 0, 3, 1'b0);
        run_seq(100, 1'b0, 2, 0, 1'b0);
        run_seq(45, 1'b0, 0, 3, 1'b0);

        run_seq(100, 1'b0, 0, 2, 1'b0);
        run_seq(60, 1'b0, 3, 0, 1'b0);
        rst = 1'b1;
        #1;
        check("arst_sync", sync_enable, 0);
        check("arst_div", div_ctl, 0);
        check("arst_mux", mux_ctl, 0);
        check("arst_busy", busy, 0);
        check("arst_nofit", no_fit, 0);
        exp_div = 0;
        exp_mux = 0;
        exp_nf  = 0;
        cfg_enable = 1'b1;
        repeat (2) @(negedge dspclk);
        rst = 1'b0;
        repeat (10) begin
            @(negedge dspclk);
            check("post_rst_sync", sync_enable, 0);
            check("post_rst_busy", busy, 0);
            check("post_rst_div", div_ctl, 0);
        end

        for (int it = 0; it < 40; it++) begin
            f  = $urandom_range(0, 255);
            fu = ($urandom_range(0, 7) == 0);
            md = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            if (md == 3) md = 4;
            run_seq(f, fu, md, $urandom_range(2, 6), md == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
